// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: runs dot-product jobs through one PE, owning its accumulator feedback and capturing the formatted result
module pe_mac_sequencer #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_MDATA = 32,
  parameter int WIDTH_LEN = 8,
  parameter int MAC_LAT = 1,
  parameter int FMT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [WIDTH_LEN-1:0]   job_len,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [WIDTH_DATA-1:0]  op_a,
  input  logic [WIDTH_DATA-1:0]  op_b,
  output logic                   pe_format_en,
  output logic [WIDTH_DATA-1:0]  pe_data_a,
  output logic [WIDTH_DATA-1:0]  pe_data_b,
  output logic [WIDTH_MDATA-1:0] pe_data_m_o,
  input  logic [WIDTH_MDATA-1:0] pe_data_m_i,
  input  logic [WIDTH_DATA-1:0]  pe_data_o,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH_DATA-1:0]  res_data,
  output logic                   busy
);
  localparam int TW = $clog2((MAC_LAT > FMT_LAT ? MAC_LAT : FMT_LAT) + 1);
  typedef enum logic [2:0] {IDLE, ACC, DRAIN, FMT, WAIT, OUT} state_t;
  state_t state;
  logic [WIDTH_LEN-1:0] len, cnt;
  logic [TW-1:0] tmr;
  logic first;
  assign job_ready = state == IDLE && !rst;
  assign op_ready = state == ACC && op_valid && !rst;
  assign busy = state != IDLE;
  assign pe_format_en = state == FMT;
  assign res_valid = state == OUT;
  assign pe_data_a = op_ready ? op_a : '0;
  assign pe_data_b = op_ready ? op_b : '0;
  assign pe_data_m_o = (state inside {ACC, DRAIN, FMT, WAIT}) && !first ? pe_data_m_i : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      len <= '0;
      cnt <= '0;
      tmr <= '0;
      first <= 1'b0;
      res_data <= '0;
    end else
      case (state)
        IDLE: if (job_valid) begin
          len <= job_len;
          cnt <= '0;
          first <= 1'b1;
          if (job_len == '0) res_data <= '0;
          state <= job_len == '0 ? OUT : ACC;
        end
        ACC: if (op_valid) begin
          first <= 1'b0;
          cnt <= cnt + 1'b1;
          if (cnt == len - WIDTH_LEN'(1)) begin
            tmr <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          tmr <= tmr + 1'b1;
          if (int'(tmr) + 1 == MAC_LAT) state <= FMT;
        end
        FMT: begin
          tmr <= '0;
          if (FMT_LAT == 1) res_data <= pe_data_o;
          state <= FMT_LAT == 1 ? OUT : WAIT;
        end
        WAIT: begin
          tmr <= tmr + 1'b1;
          if (int'(tmr) + 2 == FMT_LAT) begin
            res_data <= pe_data_o;
            state <= OUT;
          end
        end
        OUT: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: doc/pe_mac_sequencer.md
Name: pe_mac_sequencer

Overview:
- Sequences one process_element (16-bit operands, 32-bit accumulator feedback) through complete dot-product jobs.
- Accepts a job length, then streams that many operand pairs into the PE and owns the accumulator feedback loop, clearing it at job start.
- After the last product it drains the PE, pulses format_en and captures the formatted 16-bit result on a valid/ready output.
- Sits between the operand-fetch logic and a single PE instance.

Parameters:
- WIDTH_DATA, 16, operand and formatted-result width.
- WIDTH_MDATA, 32, accumulator width.
- WIDTH_LEN, 8, job length field width (max job 2^WIDTH_LEN-1 pairs).
- MAC_LAT, 1, cycles from operand presented to its product visible on pe_data_m_i (≥1).
- FMT_LAT, 1, cycles from format_en pulse to valid pe_data_o (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job request.
- job_ready  out  1  sequencer can accept a job.
- job_len  in  WIDTH_LEN  operand pairs in the job.
- op_valid  in  1  operand pair available.
- op_ready  out  1  operand pair consumed this cycle.
- op_a  in  WIDTH_DATA  operand A.
- op_b  in  WIDTH_DATA  operand B.
- pe_format_en  out  1  to PE format_en_i.
- pe_data_a  out  WIDTH_DATA  to PE data_a_i.
- pe_data_b  out  WIDTH_DATA  to PE data_b_i.
- pe_data_m_o  out  WIDTH_MDATA  to PE data_m_i (gated feedback).
- pe_data_m_i  in  WIDTH_MDATA  from PE data_m_o.
- pe_data_o  in  WIDTH_DATA  from PE data_o.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  WIDTH_DATA  captured result.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - All counters are 0.
  - res_valid=0, res_data=0, pe_format_en=0, busy=0, op_ready=0.
  - pe_data_a, pe_data_b and pe_data_m_o are 0.
  - job_ready is 0 while rst is high, and 1 in the first cycle after.
- Reset mid-job abandons the job immediately. No result is produced and any unconsumed operands stay in the source.
- States: IDLE, ACC, DRAIN, FMT, WAIT, OUT.
- IDLE:
  - job_ready=1; operands are driven 0; pe_data_m_o=0.
  - job_valid with job_len>0: latch the length, clear the accepted count, set the first flag, go to ACC.
  - job_valid with job_len=0: set res_data=0, go to OUT. The PE is untouched.
- ACC:
  - op_ready = op_valid; a pair is consumed in every cycle where op_valid=1.
  - On consume, pe_data_a/b are op_a/op_b combinationally. Otherwise they are 0, so 0*0 keeps the accumulator.
  - pe_data_m_o = 0 on the first consumed pair of the job, else pe_data_m_i. This feedback rule holds in ACC, DRAIN and FMT.
  - Stall cycles before the first pair also drive pe_data_m_o=0.
  - The count increments per consume. When the consume makes count == len, go to DRAIN with the drain counter at 0.
- DRAIN:
  - Operands are 0; lasts exactly MAC_LAT cycles, then go to FMT.
- FMT:
  - pe_format_en=1 for exactly one cycle, operands 0, then go to WAIT.
- WAIT:
  - FMT_LAT-1 cycles (zero cycles if FMT_LAT=1).
  - In its final cycle (or on leaving FMT when FMT_LAT=1), register res_data <= pe_data_o and go to OUT.
- OUT:
  - res_valid=1; res_data is held stable until res_ready.
  - On res_valid & res_ready, go to IDLE. A new job is accepted no earlier than the following cycle.
- Latency: an uninterrupted job of length N has res_valid asserted N+MAC_LAT+FMT_LAT+1 cycles after job acceptance.
- op_ready is never asserted outside ACC. Extra operands beyond job_len are not consumed.
- job_ready is 0 in every state except IDLE. A job_valid held during a running job waits.
- Length counter is WIDTH_LEN bits. A maximum-length job (all ones) must not wrap before the compare.

Test Plan:
- Reset, then a job with len=16 and pairs a=b=i for i=1..16 back-to-back:
  - op_ready high for 16 consecutive cycles.
  - pe_data_m_i reaches 1496 (0x5D8) before pe_format_en.
  - pe_format_en pulses exactly once.
  - res_data equals pe_data_o sampled FMT_LAT cycles after the pulse.
  - res_valid asserts 19 cycles after acceptance (defaults).
- Two consecutive len=4 jobs, a=b=2 then a=b=3:
  - Second job accumulates 36, not 52 (clear on first pair).
  - job_ready is low during job 1.
- len=3 with op_valid deasserted 2 cycles between each pair:
  - Stall cycles drive zero operands and the accumulation stays 14 for a=b=1,2,3.
  - op_ready is high only on valid cycles.
- len=0 job:
  - res_valid next cycle with res_data=0; no pe_format_en pulse; op_ready never high.
- res_ready held low 5 cycles in OUT:
  - res_valid and res_data stable throughout.
  - job_valid with a new job is ignored until the handshake completes.
- rst asserted in ACC after 5 of 16 pairs:
  - Next cycle state IDLE with all outputs at reset values.
  - A new len=2 job (a=b=5) yields accumulator 50.
